ft232_tx_sender: RTL and testbench



---
 rtl/ft232_pkg.sv | 19 +
 rtl/sync_fifo_8.sv | 68 ++++++
 rtl/ft232_tx_sender.sv | 91 +++++++++
 tb/tb_ft232_tx_sender.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ft232_pkg.sv
// ft232_pkg
//   Shared types and constants for the FT232 transmit path.
//   tx_state_t     : drain FSM states
//   FT_SEND_CYCLES : length of the interface's internal write sequence (WR strobe + release)
//   DEFAULT_GAP    : default hold-off after each issue pulse
package ft232_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } tx_state_t;

  localparam int FT_SEND_CYCLES = 3;

  // One cycle of margin beyond the interface write sequence so the bus is
  // fully released before the next byte is offered.
  localparam int DEFAULT_GAP = FT_SEND_CYCLES + 1;

endpackage

// File: rtl/sync_fifo_8.sv
// sync_fifo_8
//   Byte-wide synchronous FIFO with registered status.
//   clock, reset (async, active-low)
//   wr_data/wr_en    : push side; push accepted when wr_en=1 and full=0
//   rd_en/rd_data    : pop side; rd_data shows the head entry (mem[rd_ptr])
//   full/empty/count : registered occupancy, always mutually consistent
//   overflow         : high in any cycle with wr_en=1 while full=1 (byte dropped)
module sync_fifo_8 #(
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        wr_data,
  input  logic              wr_en,
  input  logic              rd_en,
  output logic [7:0]        rd_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count_nxt;
  logic              push;
  logic              pop;

  // full/empty are the registered values from the start of the cycle, so a
  // pop in the same cycle never makes room for a write to a full FIFO.
  assign push     = wr_en & ~full;
  assign pop      = rd_en & ~empty;
  assign overflow = wr_en & full;
  assign rd_data  = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Pointers are ADDR_W wide and DEPTH is a power of two, so they wrap for free.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == (ADDR_W+1)'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/ft232_tx_sender.sv
// ft232_tx_sender
//   Buffers user bytes and paces them into the FT232 interface send port.
//   clock, reset (async, active-low)
//   wr_data/wr_en          : user byte input
//   full/empty/count       : FIFO occupancy
//   overflow               : write attempted while full (byte dropped)
//   send_data/send_flag    : byte and one-cycle issue pulse to the interface
//   send_available         : interface ready, sampled only when idle
//
//   state | meaning
//   IDLE  | waiting for a queued byte and send_available; issues on the next edge
//   HOLD  | issue done; counting GAP cycles so the interface write completes
module ft232_tx_sender
  import ft232_pkg::*;
#(
  parameter  int DEPTH  = 16,
  parameter  int GAP    = DEFAULT_GAP,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        wr_data,
  input  logic              wr_en,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic [7:0]        send_data,
  output logic              send_flag,
  input  logic              send_available
);

  // Holds values up to GAP-1.
  localparam int GAP_W = $clog2(GAP);

  tx_state_t        state;
  logic [GAP_W-1:0] gap_cnt;
  logic             pop;
  logic [7:0]       head_data;

  assign pop = (state == IDLE) & ~empty & send_available;

  sync_fifo_8 #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .rd_en    (pop),
    .rd_data  (head_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow)
  );

  // HOLD lasts GAP cycles and IDLE needs one more to issue, giving GAP+1
  // cycles between issue pulses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      gap_cnt   <= '0;
      send_flag <= 1'b0;
      send_data <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            send_data <= head_data;
            send_flag <= 1'b1;
            gap_cnt   <= GAP_W'(GAP - 1);
            state     <= HOLD;
          end else begin
            send_flag <= 1'b0;
          end
        end
        HOLD: begin
          send_flag <= 1'b0;
          if (gap_cnt == '0) state <= IDLE;
          else               gap_cnt <= gap_cnt - 1'b1;
        end
        default: begin
          send_flag <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ft232_tx_sender.sv
module tb_ft232_tx_sender;

  localparam int DEPTH = 16;
  localparam int GAP   = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_en = 1'b0;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic [7:0] send_data;
  logic       send_flag;
  logic       send_available = 1'b0;

  ft232_tx_sender #(.DEPTH(DEPTH), .GAP(GAP)) dut (
    .clock          (clock),
    .reset          (reset),
    .wr_data        (wr_data),
    .wr_en          (wr_en),
    .full           (full),
    .empty          (empty),
    .count          (count),
    .overflow       (overflow),
    .send_data      (send_data),
    .send_flag      (send_flag),
    .send_available (send_available)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Reference model: byte queue plus "earliest cycle an issue may happen".
  logic [7:0] mq[$];
  int         cyc       = 0;
  int         ready_cyc = 0;
  bit         m_flag    = 0;
  logic [7:0] m_data    = 8'h00;
  int         dut_pulses = 0;
  bit         seen_3c   = 0;

  bit         cur_we;
  logic [7:0] cur_d;
  bit         cur_sa;

  typedef struct {
    bit         we;
    logic [7:0] d;
    bit         sa;
    bit         f;
    logic [7:0] dat;
    int         cnt;
  } vec_t;

  vec_t tbl[26];

  function automatic void chk(string n, longint act, longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", n, act, req, $time);
    end
  endfunction

  function automatic vec_t mk(bit we, logic [7:0] d, bit sa, bit f, logic [7:0] dat, int cnt);
    vec_t v;
    v.we = we; v.d = d; v.sa = sa; v.f = f; v.dat = dat; v.cnt = cnt;
    return v;
  endfunction

  function automatic void model_reset();
    mq.delete();
    ready_cyc = cyc;
    m_flag    = 0;
    m_data    = 8'h00;
  endfunction

  // Drive inputs, then check DUT against the model mid-cycle.
  task automatic pre(input bit we, input logic [7:0] d, input bit sa);
    cur_we = we; cur_d = d; cur_sa = sa;
    wr_en = we; wr_data = d; send_available = sa;
    @(negedge clock);
    if (send_flag) begin
      dut_pulses++;
      if (send_data == 8'h3C) seen_3c = 1;
    end
    chk("send_flag", send_flag, m_flag);
    chk("send_data", send_data, m_data);
    chk("count",     count,     mq.size());
    chk("empty",     empty,     mq.size() == 0);
    chk("full",      full,      mq.size() == DEPTH);
    chk("overflow",  overflow,  cur_we && mq.size() == DEPTH);
  endtask

  // Advance the model by the coming edge, then move to just after it.
  task automatic post();
    bit issue, accept;
    issue  = (cyc >= ready_cyc) && (mq.size() > 0) && cur_sa;
    accept = cur_we && (mq.size() < DEPTH);
    if (issue) begin
      m_data    = mq.pop_front();
      m_flag    = 1;
      ready_cyc = cyc + GAP + 1;
    end else begin
      m_flag = 0;
    end
    if (accept) mq.push_back(cur_d);
    cyc++;
    @(posedge clock);
    #1;
  endtask

  task automatic tick(input bit we, input logic [7:0] d, input bit sa);
    pre(we, d, sa);
    post();
  endtask

  initial begin
    int pulses0;
    int nflag;
    bit found;

    // Directed single-byte and burst timing, expectations derived by hand.
    tbl[0]  = mk(1, 8'hA5, 1, 0, 8'h00, 0);
    tbl[1]  = mk(0, 8'h00, 1, 0, 8'h00, 1);
    tbl[2]  = mk(0, 8'h00, 1, 1, 8'hA5, 0);
    tbl[3]  = mk(0, 8'h00, 1, 0, 8'hA5, 0);
    tbl[4]  = mk(0, 8'h00, 1, 0, 8'hA5, 0);
    tbl[5]  = mk(0, 8'h00, 1, 0, 8'hA5, 0);
    tbl[6]  = mk(0, 8'h00, 1, 0, 8'hA5, 0);
    tbl[7]  = mk(1, 8'h01, 1, 0, 8'hA5, 0);
    tbl[8]  = mk(1, 8'h02, 1, 0, 8'hA5, 1);
    tbl[9]  = mk(1, 8'h03, 1, 1, 8'h01, 1);
    tbl[10] = mk(1, 8'h04, 1, 0, 8'h01, 2);
    tbl[11] = mk(0, 8'h00, 1, 0, 8'h01, 3);
    tbl[12] = mk(0, 8'h00, 1, 0, 8'h01, 3);
    tbl[13] = mk(0, 8'h00, 1, 0, 8'h01, 3);
    tbl[14] = mk(0, 8'h00, 1, 1, 8'h02, 2);
    tbl[15] = mk(0, 8'h00, 1, 0, 8'h02, 2);
    tbl[16] = mk(0, 8'h00, 1, 0, 8'h02, 2);
    tbl[17] = mk(0, 8'h00, 1, 0, 8'h02, 2);
    tbl[18] = mk(0, 8'h00, 1, 0, 8'h02, 2);
    tbl[19] = mk(0, 8'h00, 1, 1, 8'h03, 1);
    tbl[20] = mk(0, 8'h00, 1, 0, 8'h03, 1);
    tbl[21] = mk(0, 8'h00, 1, 0, 8'h03, 1);
    tbl[22] = mk(0, 8'h00, 1, 0, 8'h03, 1);
    tbl[23] = mk(0, 8'h00, 1, 0, 8'h03, 1);
    tbl[24] = mk(0, 8'h00, 1, 1, 8'h04, 0);
    tbl[25] = mk(0, 8'h00, 1, 0, 8'h04, 0);

    // 1: reset, then idle with send_available high
    reset = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_flag",     send_flag, 0);
    chk("rst_data",     send_data, 8'h00);
    chk("rst_count",    count,     0);
    chk("rst_empty",    empty,     1);
    chk("rst_full",     full,      0);
    chk("rst_overflow", overflow,  0);
    reset = 1'b1;
    @(posedge clock); #1;
    model_reset();
    pulses0 = dut_pulses;
    for (int i = 0; i < 50; i++) tick(0, 8'h00, 1);
    chk("idle_no_pulse", dut_pulses - pulses0, 0);

    // 2 + 3: single byte latency, then 4-byte burst pacing
    for (int i = 0; i < 26; i++) begin
      pre(tbl[i].we, tbl[i].d, tbl[i].sa);
      chk($sformatf("tbl%0d_flag", i),  send_flag, tbl[i].f);
      chk($sformatf("tbl%0d_data", i),  send_data, tbl[i].dat);
      chk($sformatf("tbl%0d_count", i), count,     tbl[i].cnt);
      post();
    end
    for (int i = 0; i < 10; i++) tick(0, 8'h00, 1);

    // 4: fill with interface busy, overflow on the 17th write, then drain
    for (int i = 0; i < DEPTH; i++) tick(1, 8'h40 + 8'(i), 0);
    pre(1, 8'hEE, 0);
    chk("t4_full",     full,     1);
    chk("t4_count",    count,    16);
    chk("t4_overflow", overflow, 1);
    post();
    pre(0, 8'h00, 0);
    chk("t4_ovf_one_cycle", overflow, 0);
    post();
    pulses0 = dut_pulses;
    for (int i = 0; i < 100; i++) tick(0, 8'h00, 1);
    chk("t4_drained_16", dut_pulses - pulses0, 16);

    // 5: full FIFO, drain while writing continuously; wrap-around over 40+ bytes
    for (int i = 0; i < DEPTH; i++) tick(1, 8'($urandom), 0);
    pulses0 = dut_pulses;
    for (int i = 0; i < 130; i++) tick(1, 8'($urandom), 1);
    for (int i = 0; i < 100; i++) tick(0, 8'h00, 1);
    chk("t5_passed_40", (dut_pulses - pulses0) >= 40, 1);
    chk("t5_empty_end", empty, 1);

    // Randomized traffic with random interface readiness
    for (int i = 0; i < 600; i++)
      tick(($urandom_range(0, 1) == 1), 8'($urandom), ($urandom_range(0, 9) < 7));
    for (int i = 0; i < 100; i++) tick(0, 8'h00, 1);

    // 6: reset mid-burst while send_flag is high
    for (int i = 0; i < 5; i++) tick(1, 8'h90 + 8'(i), 1);
    nflag = 0;
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick(0, 8'h00, 1);
      if (m_flag) nflag++;
      if (nflag == 2) found = 1;
    end
    chk("t6_pulse_found", found, 1);
    chk("t6_flag_before", send_flag, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_flag_async",  send_flag, 0);
    chk("t6_count_async", count,     0);
    chk("t6_empty_async", empty,     1);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    model_reset();
    pulses0 = dut_pulses;
    for (int i = 0; i < 20; i++) tick(0, 8'h00, 1);
    chk("t6_no_leftover", dut_pulses - pulses0, 0);
    tick(1, 8'h3C, 1);
    for (int i = 0; i < 10; i++) tick(0, 8'h00, 1);
    chk("t6_fresh_3c", seen_3c, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
